// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer-side request/ack signals and the fifo write-port
//   signals seen by fifo_wr_arbiter.
//   slave  : the arbiter's view (consumes requests, drives the fifo write port)
//   master : the environment's view (producers and the fifo)
//   WIDTH and NUM_REQ must match the arbiter instance attached to it.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       i_req_stb;
   logic [NUM_REQ*WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]       o_req_ack;
   logic [NUM_REQ-1:0]       o_grant;
   logic                     o_busy;
   logic                     o_fifo_w_stb;
   logic [WIDTH-1:0]         o_fifo_w_data;
   logic                     i_fifo_full;
   logic [15:0]              o_stall_cnt;

   modport slave (
      input  i_req_stb, i_req_data, i_fifo_full,
      output o_req_ack, o_grant, o_busy, o_fifo_w_stb, o_fifo_w_data, o_stall_cnt
   );

   modport master (
      output i_req_stb, i_req_data, i_fifo_full,
      input  o_req_ack, o_grant, o_busy, o_fifo_w_stb, o_fifo_w_data, o_stall_cnt
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one fifo write port between NUM_REQ producers. Ownership is granted
//   round-robin and limited to MAX_BURST accepted words per grant, after which
//   the next pending producer takes over without an idle cycle. The owner's
//   word is muxed onto the fifo write port and acked in the same cycle.
//
//   Optional feature macro: FIFO_ARB_STALL_CNT_EN
//     defined     -> o_stall_cnt counts cycles the owner is blocked by a full
//                    fifo (saturating at 16'hFFFF)
//     not defined -> o_stall_cnt is tied to zero, no counter flops
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   fifo_wr_arbiter_if.slave  bus
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    owner, owner_nx;
   logic [IDX_W-1:0]    last, last_nx;
   logic [BEAT_W-1:0]   beat_cnt, beat_nx;

   logic [NUM_REQ-1:0]  owner_oh;
   logic [NUM_REQ-1:0]  others;
   logic                owner_req;
   logic                accept;
   logic                burst_end;

   // Round-robin pick: first set bit of mask searching base+1, base+2, ...
   // wrapping at NUM_REQ. Returns base when mask is empty (callers guard).
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0] mask,
      input logic [IDX_W-1:0]   base
   );
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] pick;
      logic             found;
      idx   = base;
      pick  = base;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
         if (!found && mask[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // Owner decode and the requests competing against the current owner.
   assign owner_oh  = NUM_REQ'(1) << owner;
   assign owner_req = bus.i_req_stb[owner];
   assign others    = bus.i_req_stb & ~owner_oh;
   assign burst_end = accept && (beat_cnt == LAST_BEAT);

   // State register: FSM state, current owner, round-robin pointer, beat count.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering in simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         last     <= LAST_IDX;    // req0 wins the first tie after reset
         beat_cnt <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         last     <= last_nx;
         beat_cnt <= beat_nx;
      end
   end

   // Next-state logic: arbitration from IDLE, burst counting and release in BUSY.
   // NOTE: every variable written here gets a hold/default value first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      last_nx  = last;
      beat_nx  = beat_cnt;
      unique case (state)
         IDLE: begin
            if (|bus.i_req_stb) begin
               state_nx = BUSY;
               owner_nx = rr_pick(bus.i_req_stb, last);
               beat_nx  = '0;
            end
         end
         BUSY: begin
            if (!owner_req || burst_end) begin
               // Release: hand over to the next pending producer if any,
               // otherwise regrant a still-requesting owner, otherwise idle.
               last_nx = owner;
               beat_nx = '0;
               if (|others) begin
                  owner_nx = rr_pick(others, owner);
               end else if (!owner_req) begin
                  state_nx = IDLE;
               end
            end else if (accept) begin
               beat_nx = beat_cnt + BEAT_W'(1);
            end
            // A full fifo leaves accept low: grant held, beat count frozen.
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Output logic: grant, accept/ack pulse and fifo write-port mux.
   always_comb begin
      accept            = 1'b0;
      bus.o_grant       = '0;
      bus.o_req_ack     = '0;
      bus.o_fifo_w_stb  = 1'b0;
      bus.o_fifo_w_data = '0;
      if (state == BUSY) begin
         bus.o_grant = owner_oh;
         // Never write into a full fifo; the producer simply keeps its word.
         accept = owner_req & ~bus.i_fifo_full;
         if (accept) begin
            bus.o_fifo_w_stb  = 1'b1;
            bus.o_fifo_w_data = bus.i_req_data[int'(owner)*WIDTH +: WIDTH];
            bus.o_req_ack     = owner_oh;
         end
      end
   end

   assign bus.o_busy = (state == BUSY);

`ifdef FIFO_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt;

   // Stall counter: cycles the owner has a word but the fifo is full, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((state == BUSY) && owner_req && bus.i_fifo_full &&
                   (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign bus.o_stall_cnt = stall_cnt;
`else
   assign bus.o_stall_cnt = '0;
`endif

   // Safety properties of the write port and ack vector.
   a_no_write_when_full : assert property (
      @(posedge clk) disable iff (!rst_n) !(bus.o_fifo_w_stb && bus.i_fifo_full));
   a_ack_onehot0 : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(bus.o_req_ack));
   a_ack_owner_only : assert property (
      @(posedge clk) disable iff (!rst_n) ((bus.o_req_ack & ~bus.o_grant) == '0));

endmodule
